ir_scan_controller: RTL
=======================

// Module: ir_scan_controller
// PURPOSE
//  Shares one IRdetector between NUM_SENSORS IR phototransistor inputs.
//  - Routes one sensor at a time to the detector and discards the first (partial-window) result.
//  - Requires CONFIRM_N consecutive matching decisions per channel.
//  - Reports one result per channel per scan. Sits between the sensor pins and the
//    IRdetector; the navigation logic consumes its outputs.
// PARAMETERS
//  NUM_SENSORS  4          number of IR inputs scanned (>=2)
//  CH_W         2          channel index width, clog2(NUM_SENSORS)
//  CONFIRM_N    3          consecutive identical decisions needed to confirm (1..7)
//  MAX_TRIES    8          detector results accepted per channel before giving up (>=CONFIRM_N)
//  TIMEOUT_CYC  4_000_000  clk cycles without det_done before timeout (40 ms @ 100 MHz)
// PORTS
//  clk             in   1      system clock, 100 MHz
//  rst             in   1      asynchronous reset, active-high
//  start           in   1      1-cycle pulse: begin one scan of all channels
//  ir_in           in   NUM_SENSORS  raw sensor lines (async; 2-flop synchronised inside)
//  det_blinky      out  1      selected, synchronised sensor to IRdetector blinky input
//  det_done        in   1      IRdetector result strobe, 1 cycle
//  det_decision    in   3      IRdetector frequency class, valid with det_done
//  busy            out  1      high from start accept until scan_done
//  result_valid    out  1      1-cycle pulse, one per channel
//  result_ch       out  CH_W   channel of current result
//  result_dec      out  3      confirmed (or last seen) decision
//  result_ok       out  1      1 = CONFIRM_N matches reached; 0 = gave up / timeout
//  scan_done       out  1      1-cycle pulse after last channel reported
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; ch=0; counters 0; sync flops 0. Applies mid-scan; no result emitted.
//  - FSM: IDLE -> SETTLE -> MEASURE -> REPORT -> (SETTLE next ch | DONE) -> IDLE.
//  - IDLE: start=1 -> ch=0, busy=1 next cycle, go SETTLE. start while busy: ignored.
//  - det_blinky = sync(ir_in[ch]); mux changes the cycle after ch updates.
//  - SETTLE: first det_done on the new channel is discarded -> MEASURE.
//  - MEASURE, on each det_done:
//    - tries++.
//    - If match_cnt==0 or det_decision==last_dec: match_cnt++. Else match_cnt=1.
//    - last_dec = det_decision.
//    - match_cnt reaching CONFIRM_N -> REPORT, ok=1.
//    - Else tries==MAX_TRIES -> REPORT, ok=0, dec=last_dec.
//  - REPORT (1 cycle): result_valid=1 with result_ch/dec/ok held until next report.
//    - Clear match_cnt, tries and timer.
//    - ch==NUM_SENSORS-1 -> DONE; else ch++ and go SETTLE.
//  - DONE: scan_done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
//  - det_done coinciding with a state change is consumed by the state being left.
//    The controller never double-counts a strobe.
//  - det_done in IDLE/REPORT/DONE: ignored.
//  - Counters saturate; ch never wraps inside a scan.
// CONFIGURATION
//  IRSCAN_TIMEOUT_EN defined:
//  - Timer counts cycles in SETTLE/MEASURE and is reset by every det_done.
//  - Reaching TIMEOUT_CYC -> REPORT with result_dec=3'd0 (no signal), result_ok=0.
//  IRSCAN_TIMEOUT_EN undefined: no timer is built, and the controller waits indefinitely for det_done.
// STRUCTURE
//  - Package ir_pkg:
//    - FSM state typedef/localparams (IDLE, SETTLE, MEASURE, REPORT, DONE).
//    - Decision codes, including DEC_NONE=3'd0.
//    - DEC_W=3.
//  - Sub-module ir_vote_tracker: match_cnt, tries, last_dec, confirm/giveup flags.
//    Cleared by a clr input.
// TESTING (bench uses a behavioural IRdetector model: done every N cycles, scripted decision)
//  1. rst high mid-MEASURE on ch1 -> all outputs 0 next cycle, no result_valid, FSM IDLE.
//  2. 4 channels, model returns 3,3,3,3 -> each ch: 1st done discarded.
//     - result_ok=1, dec=3 after 4 dones.
//     - 4 result_valid pulses ch 0..3, then scan_done.
//  3. ch2 returns 2,4,4,2,2,2 (after discard) -> result_dec=2, ok=1 on the 6th counted done.
//  4. ch1 alternates 1,5 for 8 results -> result_ok=0, result_dec=5 after 8th counted done.
//  5. IRSCAN_TIMEOUT_EN, ch3 model silent -> REPORT at TIMEOUT_CYC cycles, result_dec=0, ok=0.
//  6. start pulsed while busy and det_done during REPORT -> both ignored; counts unchanged.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared types and constants for the IR sensor scan controller.
package ir_pkg;

    localparam int DEC_W = 3;
    localparam int MC_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT,
        DONE
    } state_t;

    localparam logic [DEC_W-1:0] DEC_NONE = 3'd0;
    localparam logic [DEC_W-1:0] DEC_MAX  = 3'd7;

endpackage

// File: rtl/ir_vote_tracker.sv
// Per-channel vote counter: consecutive matching decisions and attempts.
module ir_vote_tracker
    import ir_pkg::*;
#(
    parameter int CONFIRM_N = 3,
    parameter int MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hit,
    input  logic [DEC_W-1:0] dec,
    output logic [DEC_W-1:0] last_dec,
    output logic             confirm,
    output logic             giveup
);

    localparam int TR_W = $clog2(MAX_TRIES + 1);

    logic [MC_W-1:0] match_cnt;
    logic [MC_W-1:0] match_nx;
    logic [TR_W-1:0] tries;
    logic [TR_W-1:0] tries_nx;

    always_comb begin
        match_nx = match_cnt;
        tries_nx = tries;
        if (match_cnt == '0 || dec == last_dec) begin
            if (match_cnt != '1) begin
                match_nx = match_cnt + 1'b1;
            end
        end else begin
            match_nx = MC_W'(1);
        end
        if (tries != TR_W'(MAX_TRIES)) begin
            tries_nx = tries + 1'b1;
        end
    end

    // Flags describe the strobe being accepted this cycle.
    assign confirm = hit && (match_nx == MC_W'(CONFIRM_N));
    assign giveup  = hit && !confirm && (tries_nx == TR_W'(MAX_TRIES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
            tries     <= '0;
            last_dec  <= DEC_NONE;
        end else if (clr) begin
            match_cnt <= '0;
            tries     <= '0;
            last_dec  <= DEC_NONE;
        end else if (hit) begin
            match_cnt <= match_nx;
            tries     <= tries_nx;
            last_dec  <= dec;
        end
    end

endmodule

// File: rtl/ir_scan_controller.sv
// Time-multiplexes one IR detector across several sensors, voting per channel.
// Optional feature: IRSCAN_TIMEOUT_EN adds a det_done watchdog per channel.
module ir_scan_controller
    import ir_pkg::*;
#(
    parameter int NUM_SENSORS = 4,
    parameter int CH_W        = 2,
    parameter int CONFIRM_N   = 3,
    parameter int MAX_TRIES   = 8,
    parameter int TIMEOUT_CYC = 4_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_SENSORS-1:0] ir_in,
    output logic                   det_blinky,
    input  logic                   det_done,
    input  logic [DEC_W-1:0]       det_decision,
    output logic                   busy,
    output logic                   result_valid,
    output logic [CH_W-1:0]        result_ch,
    output logic [DEC_W-1:0]       result_dec,
    output logic                   result_ok,
    output logic                   scan_done
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_SENSORS - 1);

    if (NUM_SENSORS < 2) begin : g_bad_ns
        $error("NUM_SENSORS must be >= 2");
    end
    if (CONFIRM_N < 1 || CONFIRM_N > 7) begin : g_bad_cn
        $error("CONFIRM_N must be 1..7");
    end
    if (MAX_TRIES < CONFIRM_N) begin : g_bad_mt
        $error("MAX_TRIES must be >= CONFIRM_N");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_to
        $error("TIMEOUT_CYC must be >= 1");
    end

    state_t                 state;
    state_t                 state_nx;
    logic [CH_W-1:0]        ch;
    logic [NUM_SENSORS-1:0] sync1;
    logic [NUM_SENSORS-1:0] sync2;

    logic             hit;
    logic             clr;
    logic             confirm;
    logic             giveup;
    logic             timeout;
    logic             to_report;
    logic             rep_ok;
    logic [DEC_W-1:0] rep_dec;
    logic [DEC_W-1:0] last_dec;

    ir_vote_tracker #(
        .CONFIRM_N(CONFIRM_N),
        .MAX_TRIES(MAX_TRIES)
    ) u_vote (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .hit     (hit),
        .dec     (det_decision),
        .last_dec(last_dec),
        .confirm (confirm),
        .giveup  (giveup)
    );

`ifdef IRSCAN_TIMEOUT_EN
    localparam int TM_W = $clog2(TIMEOUT_CYC + 1);

    logic [TM_W-1:0] timer;
    logic            waiting;

    assign waiting = (state == SETTLE) || (state == MEASURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (!waiting || det_done) begin
            timer <= '0;
        end else if (timer != TM_W'(TIMEOUT_CYC)) begin
            timer <= timer + 1'b1;
        end
    end

    // A strobe in the expiry cycle still wins over the watchdog.
    assign timeout = waiting && !det_done &&
                     (timer == TM_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        hit       = 1'b0;
        clr       = 1'b0;
        to_report = 1'b0;
        rep_ok    = 1'b0;
        rep_dec   = DEC_NONE;
        unique case (state)
            IDLE: begin
                clr = 1'b1;
                if (start) begin
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (det_done) begin
                    state_nx = MEASURE;
                end else if (timeout) begin
                    to_report = 1'b1;
                end
            end
            MEASURE: begin
                hit = det_done;
                if (confirm) begin
                    to_report = 1'b1;
                    rep_ok    = 1'b1;
                    rep_dec   = det_decision;
                end else if (giveup) begin
                    to_report = 1'b1;
                    rep_dec   = det_decision;
                end else if (timeout) begin
                    to_report = 1'b1;
                end
            end
            REPORT: begin
                clr      = 1'b1;
                state_nx = (ch == LAST_CH) ? DONE : SETTLE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (to_report) begin
            state_nx = REPORT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch <= '0;
        end else if (state == IDLE && start) begin
            ch <= '0;
        end else if (state == REPORT && ch != LAST_CH) begin
            ch <= ch + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_ch  <= '0;
            result_dec <= DEC_NONE;
            result_ok  <= 1'b0;
        end else if (to_report) begin
            result_ch  <= ch;
            result_dec <= rep_dec;
            result_ok  <= rep_ok;
        end
    end

    // Registered mux output lags a channel change by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            det_blinky <= 1'b0;
        end else begin
            sync1      <= ir_in;
            sync2      <= sync1;
            det_blinky <= sync2[ch];
        end
    end

    assign busy = (state == SETTLE) || (state == MEASURE) ||
                  (state == REPORT);
    assign result_valid = (state == REPORT);
    assign scan_done    = (state == DONE);

endmodule
